// File: rtl/cpsr_unit_pkg.sv
// Shared definitions for the ARM7TDMI status-register block: mode and condition
// encodings, CPSR bit positions, reset value and small decode helpers.
package cpsr_unit_pkg;

  localparam logic [31:0] RESET_CPSR_DEF = 32'h0000_00D3;
  // Only the flag nibble and the control byte exist in hardware.
  localparam logic [31:0] STORED_MASK    = 32'hF000_00FF;

  localparam int BIT_N = 31;
  localparam int BIT_Z = 30;
  localparam int BIT_C = 29;
  localparam int BIT_V = 28;
  localparam int BIT_I = 7;
  localparam int BIT_F = 6;
  localparam int BIT_T = 5;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  function automatic logic mode_valid(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Modes that own a banked SPSR.
  function automatic logic mode_banked(input logic [4:0] m);
    case (m)
      MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}} & STORED_MASK;
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator: decides whether an instruction with condition
// field cond_i executes under flags n/z/c/v. Purely combinational.
module arm_cond_check
  import cpsr_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       pass_o
);

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z_i;
      COND_NE: pass_o = !z_i;
      COND_CS: pass_o = c_i;
      COND_CC: pass_o = !c_i;
      COND_MI: pass_o = n_i;
      COND_PL: pass_o = !n_i;
      COND_VS: pass_o = v_i;
      COND_VC: pass_o = !v_i;
      COND_HI: pass_o = c_i && !z_i;
      COND_LS: pass_o = !c_i || z_i;
      COND_GE: pass_o = (n_i == v_i);
      COND_LT: pass_o = (n_i != v_i);
      COND_GT: pass_o = !z_i && (n_i == v_i);
      COND_LE: pass_o = z_i || (n_i != v_i);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpsr_unit.sv
// ARM7TDMI CPSR plus banked SPSRs: flag capture, MSR/MRS, exception entry and
// SPSR->CPSR restore, with condition evaluation on the live flags.
module cpsr_unit
  import cpsr_unit_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR = RESET_CPSR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        flags_we,
  input  logic [3:0]  cond,
  output logic        cond_pass,
  input  logic        msr_we,
  input  logic        msr_spsr,
  input  logic [3:0]  msr_mask,
  input  logic [31:0] msr_data,
  output logic [31:0] mrs_data,
  input  logic        exc_valid,
  input  logic [4:0]  exc_mode,
  input  logic        exc_fiq_mask,
  input  logic        ret_valid,
  output logic        o_n,
  output logic        o_z,
  output logic        o_c,
  output logic        o_v,
  output logic [31:0] cpsr,
  output logic [4:0]  mode,
  output logic        thumb,
  output logic        irq_mask,
  output logic        fiq_mask,
  output logic        mode_err
);

  // Every strobe is a single-cycle request sampled at posedge clk and always
  // accepted (no ready); when several coincide only the highest-priority one
  // (exc_valid > ret_valid > msr_we > flags_we) has any effect.

  logic [31:0] cpsr_q, cpsr_d;
  logic [31:0] spsr_fiq_q, spsr_fiq_d;
  logic [31:0] spsr_irq_q, spsr_irq_d;
  logic [31:0] spsr_svc_q, spsr_svc_d;
  logic [31:0] spsr_abt_q, spsr_abt_d;
  logic [31:0] spsr_und_q, spsr_und_d;
  logic        mode_err_q, mode_err_d;

  logic [4:0]  cur_mode;
  logic        cur_banked;
  logic [31:0] cur_spsr;
  logic [31:0] cpsr_wmask;
  logic [31:0] spsr_wmask;
  logic        spsr_wr;
  logic [4:0]  spsr_wr_mode;
  logic [31:0] spsr_wr_data;

  assign cur_mode   = cpsr_q[4:0];
  assign cur_banked = mode_banked(cur_mode);

  // Outside banked modes this falls back to CPSR, which is what MRS SPSR returns.
  always_comb begin
    cur_spsr = cpsr_q;
    case (cur_mode)
      MODE_FIQ: cur_spsr = spsr_fiq_q;
      MODE_IRQ: cur_spsr = spsr_irq_q;
      MODE_SVC: cur_spsr = spsr_svc_q;
      MODE_ABT: cur_spsr = spsr_abt_q;
      MODE_UND: cur_spsr = spsr_und_q;
      default:  cur_spsr = cpsr_q;
    endcase
  end

  always_comb begin
    cpsr_d       = cpsr_q;
    spsr_fiq_d   = spsr_fiq_q;
    spsr_irq_d   = spsr_irq_q;
    spsr_svc_d   = spsr_svc_q;
    spsr_abt_d   = spsr_abt_q;
    spsr_und_d   = spsr_und_q;
    mode_err_d   = 1'b0;
    spsr_wr      = 1'b0;
    spsr_wr_mode = cur_mode;
    spsr_wr_data = cpsr_q;
    cpsr_wmask   = field_mask((cur_mode == MODE_USR) ? (msr_mask & 4'b1000) : msr_mask);
    spsr_wmask   = field_mask(msr_mask);

    if (exc_valid) begin
      if (mode_banked(exc_mode)) begin
        spsr_wr           = 1'b1;
        spsr_wr_mode      = exc_mode;
        spsr_wr_data      = cpsr_q;
        cpsr_d[4:0]       = exc_mode;
        cpsr_d[BIT_T]     = 1'b0;
        cpsr_d[BIT_I]     = 1'b1;
        if (exc_fiq_mask) cpsr_d[BIT_F] = 1'b1;
      end else begin
        mode_err_d = 1'b1;
      end
    end else if (ret_valid) begin
      if (cur_banked) begin
        if (mode_valid(cur_spsr[4:0])) cpsr_d = cur_spsr & STORED_MASK;
        else                           mode_err_d = 1'b1;
      end
    end else if (msr_we) begin
      if (!msr_spsr) begin
        // A bad mode kills only the control byte; the flag byte still lands.
        if (cpsr_wmask[0] && !mode_valid(msr_data[4:0])) begin
          cpsr_wmask[7:0] = 8'h00;
          mode_err_d      = 1'b1;
        end
        cpsr_d = (cpsr_q & ~cpsr_wmask) | (msr_data & cpsr_wmask);
      end else if (cur_banked) begin
        spsr_wr      = 1'b1;
        spsr_wr_mode = cur_mode;
        spsr_wr_data = (cur_spsr & ~spsr_wmask) | (msr_data & spsr_wmask);
      end
    end else if (flags_we) begin
      cpsr_d[31:28] = {alu_n, alu_z, alu_c, alu_v};
    end

    if (spsr_wr) begin
      case (spsr_wr_mode)
        MODE_FIQ: spsr_fiq_d = spsr_wr_data;
        MODE_IRQ: spsr_irq_d = spsr_wr_data;
        MODE_SVC: spsr_svc_d = spsr_wr_data;
        MODE_ABT: spsr_abt_d = spsr_wr_data;
        MODE_UND: spsr_und_d = spsr_wr_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpsr_q     <= RESET_CPSR & STORED_MASK;
      spsr_fiq_q <= '0;
      spsr_irq_q <= '0;
      spsr_svc_q <= '0;
      spsr_abt_q <= '0;
      spsr_und_q <= '0;
      mode_err_q <= 1'b0;
    end else begin
      cpsr_q     <= cpsr_d;
      spsr_fiq_q <= spsr_fiq_d;
      spsr_irq_q <= spsr_irq_d;
      spsr_svc_q <= spsr_svc_d;
      spsr_abt_q <= spsr_abt_d;
      spsr_und_q <= spsr_und_d;
      mode_err_q <= mode_err_d;
    end
  end

  arm_cond_check u_cond (
    .cond_i (cond),
    .n_i    (cpsr_q[BIT_N]),
    .z_i    (cpsr_q[BIT_Z]),
    .c_i    (cpsr_q[BIT_C]),
    .v_i    (cpsr_q[BIT_V]),
    .pass_o (cond_pass)
  );

  assign mrs_data = msr_spsr ? cur_spsr : cpsr_q;
  assign cpsr     = cpsr_q;
  assign mode     = cpsr_q[4:0];
  assign thumb    = cpsr_q[BIT_T];
  assign irq_mask = cpsr_q[BIT_I];
  assign fiq_mask = cpsr_q[BIT_F];
  assign o_n      = cpsr_q[BIT_N];
  assign o_z      = cpsr_q[BIT_Z];
  assign o_c      = cpsr_q[BIT_C];
  assign o_v      = cpsr_q[BIT_V];
  assign mode_err = mode_err_q;

endmodule

// File: tb/tb_cpsr_unit.sv
// Bench for cpsr_unit: directed scenarios then random strobes, checked against
// an architectural model of the status registers via expected-value queues.
module tb_cpsr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        flags_we;
  logic [3:0]  cond;
  logic        cond_pass;
  logic        msr_we, msr_spsr;
  logic [3:0]  msr_mask;
  logic [31:0] msr_data;
  logic [31:0] mrs_data;
  logic        exc_valid;
  logic [4:0]  exc_mode;
  logic        exc_fiq_mask;
  logic        ret_valid;
  logic        o_n, o_z, o_c, o_v;
  logic [31:0] cpsr;
  logic [4:0]  mode;
  logic        thumb, irq_mask, fiq_mask, mode_err;

  always #5 clk = ~clk;

  cpsr_unit dut (
    .clk(clk), .rst(rst),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flags_we(flags_we), .cond(cond), .cond_pass(cond_pass),
    .msr_we(msr_we), .msr_spsr(msr_spsr), .msr_mask(msr_mask),
    .msr_data(msr_data), .mrs_data(mrs_data),
    .exc_valid(exc_valid), .exc_mode(exc_mode), .exc_fiq_mask(exc_fiq_mask),
    .ret_valid(ret_valid),
    .o_n(o_n), .o_z(o_z), .o_c(o_c), .o_v(o_v),
    .cpsr(cpsr), .mode(mode), .thumb(thumb), .irq_mask(irq_mask),
    .fiq_mask(fiq_mask), .mode_err(mode_err)
  );

  int tests = 0;
  int fails = 0;

  // {mode_err, cpsr} after each edge, and {cond_pass, mrs_data} during each cycle.
  logic [32:0] exp_q[$];
  logic [32:0] comb_q[$];

  // Architectural model: CPSR and one SPSR slot per mode encoding.
  logic [31:0] m_cpsr;
  logic [31:0] m_spsr [32];
  logic [4:0]  modes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};

  function automatic bit is_valid(input logic [4:0] m);
    return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
  endfunction

  function automatic bit is_banked(input logic [4:0] m);
    return m inside {5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};
  endfunction

  function automatic bit cond_model(input logic [3:0] cc, input logic [31:0] p);
    bit n, z, c, v;
    n = p[31]; z = p[30]; c = p[29]; v = p[28];
    case (cc)
      4'h0: return z;            4'h1: return !z;
      4'h2: return c;            4'h3: return !c;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return c && !z;      4'h9: return !c || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs, record expectations, advance the model.
  task automatic drive(input logic r, input logic ex, input logic [4:0] em, input logic fm,
                       input logic rt, input logic mw, input logic sp, input logic [3:0] mk,
                       input logic [31:0] md, input logic fw, input logic [3:0] nzcv,
                       input logic [3:0] cc);
    logic       err;
    logic [4:0] cur;
    logic [3:0] mk2;
    logic [31:0] s;
    @(negedge clk);
    rst = r; exc_valid = ex; exc_mode = em; exc_fiq_mask = fm; ret_valid = rt;
    msr_we = mw; msr_spsr = sp; msr_mask = mk; msr_data = md; flags_we = fw;
    {alu_n, alu_z, alu_c, alu_v} = nzcv; cond = cc;

    cur = m_cpsr[4:0];
    comb_q.push_back({cond_model(cc, m_cpsr), (sp && is_banked(cur)) ? m_spsr[cur] : m_cpsr});

    err = 1'b0;
    if (r) begin
      m_cpsr = 32'h0000_00D3;
      foreach (m_spsr[i]) m_spsr[i] = '0;
    end else if (ex) begin
      if (is_banked(em)) begin
        m_spsr[em] = m_cpsr;
        m_cpsr = {m_cpsr[31:28], 20'b0, 1'b1, (fm ? 1'b1 : m_cpsr[6]), 1'b0, em};
      end else err = 1'b1;
    end else if (rt) begin
      if (is_banked(cur)) begin
        s = m_spsr[cur];
        if (is_valid(s[4:0])) m_cpsr = s;
        else err = 1'b1;
      end
    end else if (mw) begin
      if (!sp) begin
        mk2 = (cur == 5'h10) ? (mk & 4'b1000) : mk;
        if (mk2[3]) m_cpsr[31:28] = md[31:28];
        if (mk2[0]) begin
          if (is_valid(md[4:0])) m_cpsr[7:0] = md[7:0];
          else err = 1'b1;
        end
      end else if (is_banked(cur)) begin
        if (mk[3]) m_spsr[cur][31:28] = md[31:28];
        if (mk[0]) m_spsr[cur][7:0]   = md[7:0];
      end
    end else if (fw) begin
      m_cpsr[31:28] = nzcv;
    end
    exp_q.push_back({err, m_cpsr});
  endtask

  task automatic idle(input logic [3:0] cc, input logic sp);
    drive(1'b0, 1'b0, 5'h0, 1'b0, 1'b0, 1'b0, sp, 4'h0, 32'h0, 1'b0, 4'h0, cc);
  endtask

  logic [32:0] ce, se;

  // Combinational outputs, checked mid-cycle against the pre-edge state.
  always @(negedge clk) begin
    #1;
    if (comb_q.size() > 0) begin
      ce = comb_q.pop_front();
      check("cond_pass", {31'b0, cond_pass}, {31'b0, ce[32]});
      check("mrs_data", mrs_data, ce[31:0]);
    end
  end

  // Registered state, checked just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      se = exp_q.pop_front();
      check("cpsr", cpsr, se[31:0]);
      check("mode_err", {31'b0, mode_err}, {31'b0, se[32]});
      check("status_pins",
            {19'b0, mode, thumb, irq_mask, fiq_mask, o_n, o_z, o_c, o_v},
            {19'b0, se[4:0], se[5], se[7], se[6], se[31:28]});
    end
  end

  initial begin
    logic        r, ex, fm, rt, mw, sp, fw;
    logic [4:0]  em;
    logic [3:0]  mk, nzcv, cc;
    logic [31:0] md;

    rst = 1'b1; exc_valid = 0; exc_mode = 0; exc_fiq_mask = 0; ret_valid = 0;
    msr_we = 0; msr_spsr = 0; msr_mask = 0; msr_data = 0; flags_we = 0;
    alu_n = 0; alu_z = 0; alu_c = 0; alu_v = 0; cond = 0;
    m_cpsr = 32'h0000_00D3;
    foreach (m_spsr[i]) m_spsr[i] = '0;
    repeat (2) @(posedge clk);

    // Reset, then SPSR_svc reads zero.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
    idle(4'hE, 1'b1);
    // Flag capture n=0 z=1 c=1 v=0, then EQ/CS pass, NE/HI fail.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0110, 4'hE);
    idle(4'h0, 1'b0); idle(4'h2, 1'b0); idle(4'h1, 1'b0); idle(4'h8, 1'b0);
    // IRQ entry from SVC, read SPSR_irq, return.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
    drive(0, 1, 5'h12, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
    idle(4'hE, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'hE);
    // Enter USR, then a full-mask MSR only reaches the flags.
    drive(0, 0, 0, 0, 0, 1, 0, 4'b0001, 32'h0000_0010, 0, 0, 4'hE);
    drive(0, 0, 0, 0, 0, 1, 0, 4'b1111, 32'hF000_00DF, 0, 0, 4'hE);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'hE);
    drive(0, 1, 5'h10, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
    // Invalid mode via MSR CPSR, then via an SPSR restore.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
    drive(0, 0, 0, 0, 0, 1, 0, 4'b0001, 32'h0000_0015, 0, 0, 4'hE);
    idle(4'hE, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 1, 4'b1001, 32'hA000_0005, 0, 0, 4'hE);
    idle(4'hE, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'hE);
    // Exception, MSR and flag write together: only the exception lands.
    drive(0, 1, 5'h11, 1, 0, 1, 0, 4'b1111, 32'hF000_0010, 1, 4'b1111, 4'hE);
    idle(4'hE, 1'b1);

    for (int k = 0; k < 1500; k++) begin
      r    = ($urandom_range(0, 99) == 0);
      ex   = ($urandom_range(0, 7) == 0);
      em   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : modes[$urandom_range(0, 6)];
      fm   = 1'($urandom);
      rt   = ($urandom_range(0, 5) == 0);
      mw   = ($urandom_range(0, 3) == 0);
      sp   = 1'($urandom);
      mk   = 4'($urandom);
      md   = $urandom;
      if ($urandom_range(0, 3) != 0) md[4:0] = modes[$urandom_range(0, 6)];
      fw   = 1'($urandom);
      nzcv = 4'($urandom);
      cc   = 4'($urandom);
      drive(r, ex, em, fm, rt, mw, sp, mk, md, fw, nzcv, cc);
    end

    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0 || comb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d state and %0d comb entries left, expected 0",
               exp_q.size(), comb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
